// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / DMA-debug) arbiter in front of a single-ported
// data memory with combinational read data and one-cycle read latency.
//
// Optional feature: define DMEM_ARB_RR_EN to switch the contention policy to
// strict round-robin. Without it the CPU has priority, but a CPU burst of
// MAX_BURST consecutive grants yields one slot to the DMA port when both wait.
//
// Handshake (both ports): a master holds x_req (with x_we/x_addr/x_wdata
// stable) until it sees x_gnt high in the same cycle; the access is accepted
// on that clock edge. A read returns x_rdata with x_rvalid high for exactly
// the cycle after the grant. A new request may be made in the rvalid cycle.
//
// Debug: dbg_state exposes the FSM state (0=IDLE, 1=OWN_C, 2=OWN_D) and
// dbg_burst_cnt the current burst counter.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  // DMA / debug port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // Data memory
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // Debug visibility
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        c_pick;
  logic        d_pick;
  logic [3:0]  burst_inc;

  // Arbitration: pick a winner from current requests and registered owner state
  always_comb begin
    c_pick = 1'b0;
    d_pick = 1'b0;
    if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
      // Strict alternation; from IDLE the CPU goes first.
      if (state_q == OWN_C) d_pick = 1'b1;
      else                  c_pick = 1'b1;
`else
      // CPU priority, but a full CPU burst hands one slot to the DMA port.
      if (state_q == OWN_C && burst_cnt_q == BURST_MAX) d_pick = 1'b1;
      else                                              c_pick = 1'b1;
`endif
    end else begin
      c_pick = c_req;
      d_pick = d_req;
    end
    // No access may be accepted while reset is asserted.
    c_gnt = c_pick & ~reset;
    d_gnt = d_pick & ~reset;
  end

  // Memory-side mux: granted port passes through unmodified, zeros otherwise
  always_comb begin
    mem_addr  = 32'd0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_we    = c_we;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end
  end

  // Next-state, burst counter and read-return computation
  always_comb begin
    burst_inc   = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
    state_d     = IDLE;
    burst_cnt_d = burst_cnt_q;
    if (c_gnt) begin
      state_d     = OWN_C;
      burst_cnt_d = (state_q == OWN_C) ? burst_inc : 4'd1;
    end else if (d_gnt) begin
      state_d     = OWN_D;
      burst_cnt_d = (state_q == OWN_D) ? burst_inc : 4'd1;
    end

    c_rvalid_d = c_gnt & ~c_we;
    d_rvalid_d = d_gnt & ~d_we;
    c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
  end

  // FSM and registered outputs; async reset discards any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      c_rvalid_q  <= c_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign c_rvalid      = c_rvalid_q;
  assign d_rvalid      = d_rvalid_q;
  assign c_rdata       = c_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign dbg_state     = state_q;
  assign dbg_burst_cnt = burst_cnt_q;

endmodule
